fp_expcal_pipe: RTL and testbench

FP_EXPCAL_PIPE -- requirements
Module: fp_expcal_pipe

---
 rtl/fp_exp_pkg.sv | 26 ++
 rtl/fp_exp_sat.sv | 43 ++++
 rtl/fp_expcal_pipe.sv | 129 ++++++++++++
 tb/tb_fp_expcal_pipe.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_exp_pkg.sv
// Shared constants and payload types for the floating-point exponent pipeline.
package fp_exp_pkg;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } exp_mode_e;

  localparam int unsigned EXP_WIDTH_DEF = 8;
  localparam int unsigned BIAS_DEF      = 127;
  localparam int unsigned RAW_EXTRA     = 2;
  localparam int unsigned RAW_WIDTH_DEF = EXP_WIDTH_DEF + RAW_EXTRA;

  // Operand classification captured alongside the raw sum in stage 1
  typedef struct packed {
    exp_mode_e mode;
    logic      a_zero;
    logic      b_zero;
    logic      any_inf;
  } exp_class_t;

  function automatic int unsigned raw_width(input int unsigned w);
    return w + RAW_EXTRA;
  endfunction

endpackage

// File: rtl/fp_exp_sat.sv
// Saturation, flag generation and special-operand handling for a raw signed exponent.
module fp_exp_sat
  import fp_exp_pkg::*;
#(
  parameter int unsigned EXP_WIDTH = EXP_WIDTH_DEF
) (
  input  logic signed [raw_width(EXP_WIDTH)-1:0] raw_i,
  input  exp_class_t                             cls_i,
  output logic        [EXP_WIDTH-1:0]            expr_c,
  output logic                                   ovf_c,
  output logic                                   udf_c,
  output logic                                   zero_c
);

  localparam int unsigned RW = raw_width(EXP_WIDTH);
  localparam logic signed [RW-1:0] OVF_LIM  = RW'((2 ** EXP_WIDTH) - 1);
  localparam logic signed [RW-1:0] RAW_ZERO = '0;

  // Priority: inf/NaN, zero operand, divide-by-zero, then range saturation
  always_comb begin
    expr_c = '0;
    ovf_c  = 1'b0;
    udf_c  = 1'b0;
    zero_c = 1'b0;
    if (cls_i.any_inf) begin
      ovf_c  = 1'b1;
      expr_c = '1;
    end else if (cls_i.a_zero || (cls_i.b_zero && cls_i.mode == MODE_MUL)) begin
      zero_c = 1'b1;
    end else if (cls_i.b_zero) begin
      ovf_c  = 1'b1;
      expr_c = '1;
    end else if (raw_i >= OVF_LIM) begin
      ovf_c  = 1'b1;
      expr_c = '1;
    end else if (raw_i <= RAW_ZERO) begin
      udf_c  = 1'b1;
    end else begin
      expr_c = raw_i[EXP_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/fp_expcal_pipe.sv
// Two-stage exponent calculator for FP multiply/divide with valid/ready handshakes.
module fp_expcal_pipe
  import fp_exp_pkg::*;
#(
  parameter int unsigned EXP_WIDTH = EXP_WIDTH_DEF,
  parameter int unsigned BIAS      = BIAS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 mode,
  input  logic [EXP_WIDTH-1:0] expa,
  input  logic [EXP_WIDTH-1:0] expb,
  input  logic                 nadj,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_WIDTH-1:0] expr,
  output logic                 ovf,
  output logic                 udf,
  output logic                 zero
);

  localparam int unsigned RW = raw_width(EXP_WIDTH);

  logic                 s1_valid_q, s1_valid_d;
  logic signed [RW-1:0] s1_raw_q, s1_raw_d;
  exp_class_t           s1_cls_q, s1_cls_d;

  logic                 out_valid_q, out_valid_d;
  logic [EXP_WIDTH-1:0] expr_q, expr_d;
  logic                 ovf_q, ovf_d;
  logic                 udf_q, udf_d;
  logic                 zero_q, zero_d;

  logic                 in_fire, s2_load, s1_adv;
  logic signed [RW-1:0] ea_x, eb_x, bias_x, nadj_x;

  logic [EXP_WIDTH-1:0] sat_expr;
  logic                 sat_ovf, sat_udf, sat_zero;

  // Handshake: a stage may load when empty or when it empties this cycle
  always_comb begin
    s2_load  = !out_valid_q || out_ready;
    s1_adv   = s1_valid_q && s2_load;
    in_ready = !s1_valid_q || s1_adv;
    in_fire  = in_valid && in_ready;
  end

  // Stage 1: widened signed arithmetic, no wrap possible in RW bits
  always_comb begin
    ea_x       = RW'(expa);
    eb_x       = RW'(expb);
    bias_x     = RW'(BIAS);
    nadj_x     = RW'(nadj);
    s1_valid_d = s1_valid_q;
    s1_raw_d   = s1_raw_q;
    s1_cls_d   = s1_cls_q;
    if (in_fire) begin
      s1_valid_d       = 1'b1;
      s1_raw_d         = (exp_mode_e'(mode) == MODE_DIV) ? (ea_x - eb_x + bias_x + nadj_x)
                                                        : (ea_x + eb_x - bias_x + nadj_x);
      s1_cls_d.mode    = exp_mode_e'(mode);
      s1_cls_d.a_zero  = (expa == '0);
      s1_cls_d.b_zero  = (expb == '0);
      s1_cls_d.any_inf = (expa == '1) || (expb == '1);
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  fp_exp_sat #(
    .EXP_WIDTH(EXP_WIDTH)
  ) u_sat (
    .raw_i (s1_raw_q),
    .cls_i (s1_cls_q),
    .expr_c(sat_expr),
    .ovf_c (sat_ovf),
    .udf_c (sat_udf),
    .zero_c(sat_zero)
  );

  // Stage 2: result registers hold steady until the consumer takes them
  always_comb begin
    out_valid_d = out_valid_q;
    expr_d      = expr_q;
    ovf_d       = ovf_q;
    udf_d       = udf_q;
    zero_d      = zero_q;
    if (s2_load) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        expr_d = sat_expr;
        ovf_d  = sat_ovf;
        udf_d  = sat_udf;
        zero_d = sat_zero;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_raw_q    <= '0;
      s1_cls_q    <= '0;
      out_valid_q <= 1'b0;
      expr_q      <= '0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_raw_q    <= s1_raw_d;
      s1_cls_q    <= s1_cls_d;
      out_valid_q <= out_valid_d;
      expr_q      <= expr_d;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
      zero_q      <= zero_d;
    end
  end

  assign out_valid = out_valid_q;
  assign expr      = expr_q;
  assign ovf       = ovf_q;
  assign udf       = udf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_fp_expcal_pipe.sv
// Self-checking bench for fp_expcal_pipe: reference model, directed corners and random traffic.
module tb_fp_expcal_pipe;

  typedef struct packed {
    logic [7:0] expr;
    logic       ovf;
    logic       udf;
    logic       zero;
  } res_t;

  typedef struct {
    res_t r;
    int   c;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic       mode;
  logic [7:0] expa;
  logic [7:0] expb;
  logic       nadj;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] expr;
  logic       ovf;
  logic       udf;
  logic       zero;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   n_out = 0;
  bit   chk_lat = 0;
  bit   hold_pend = 0;
  bit   last_ir = 0;
  bit   last_acc = 0;
  res_t held;
  res_t last_out;
  exp_t exp_q[$];

  fp_expcal_pipe #(
    .EXP_WIDTH(8),
    .BIAS     (127)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mode     (mode),
    .expa     (expa),
    .expb     (expb),
    .nadj     (nadj),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .expr     (expr),
    .ovf      (ovf),
    .udf      (udf),
    .zero     (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  function automatic res_t mk(int e, bit o, bit u, bit z);
    res_t r;
    r.expr = 8'(e);
    r.ovf  = o;
    r.udf  = u;
    r.zero = z;
    return r;
  endfunction

  // Reference: result exponent from the arithmetic and special-case rules
  function automatic res_t model(int a, int b, bit md, bit nj);
    int raw;
    if (a == 255 || b == 255) return mk(255, 1, 0, 0);
    if (a == 0 || (b == 0 && !md)) return mk(0, 0, 0, 1);
    if (b == 0) return mk(255, 1, 0, 0);
    raw = md ? (a - b + 127 + int'(nj)) : (a + b - 127 + int'(nj));
    if (raw >= 255) return mk(255, 1, 0, 0);
    if (raw <= 0) return mk(0, 0, 1, 0);
    return mk(raw, 0, 0, 0);
  endfunction

  function automatic int pick();
    int edges[9] = '{0, 1, 63, 64, 127, 190, 191, 254, 255};
    if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 8)];
    return int'($urandom_range(0, 255));
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  // One cycle: sample just after the negedge-driven inputs settle, then advance
  task automatic step();
    res_t cur;
    exp_t e;
    #1;
    cyc++;
    cur = {expr, ovf, udf, zero};
    chk("flags_onehot", 32'((32'(ovf) + 32'(udf) + 32'(zero)) <= 32'd1), 32'd1);
    if (out_ready) chk("in_ready_when_drained", 32'(in_ready), 32'd1);
    if (out_valid && hold_pend) chk("hold_stable", 32'(cur), 32'(held));
    if (out_valid && out_ready) begin
      n_out++;
      last_out = cur;
      chk("output_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("result", 32'(cur), 32'(e.r));
        if (chk_lat) chk("latency", 32'(cyc - e.c), 32'd2);
      end
    end
    hold_pend = out_valid && !out_ready;
    held      = cur;
    last_ir   = in_ready;
    last_acc  = in_valid && in_ready;
    if (last_acc) exp_q.push_back('{model(int'(expa), int'(expb), mode, nadj), cyc});
    @(negedge clk);
  endtask

  task automatic drain(int budget);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < budget && exp_q.size() > 0; i++) step();
    chk("drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic drive(int a, int b, bit md, bit nj);
    expa = 8'(a);
    expb = 8'(b);
    mode = md;
    nadj = nj;
  endtask

  task automatic directed(string nm, int a, int b, bit md, bit nj, res_t lit);
    chk({nm, "_model"}, 32'(model(a, b, md, nj)), 32'(lit));
    chk_lat   = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    drive(a, b, md, nj);
    step();
    chk({nm, "_accept"}, 32'(last_acc), 32'd1);
    last_out = '0;
    drain(10);
    chk({nm, "_dut"}, 32'(last_out), 32'(lit));
    chk_lat = 1'b0;
  endtask

  initial begin
    int base;
    bit got;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    drive(0, 0, 0, 0);
    held     = '0;
    last_out = '0;

    @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_result", 32'({expr, ovf, udf, zero}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    directed("mul_130_125", 130, 125, 0, 0, mk(128, 0, 0, 0));
    directed("mul_ovf", 200, 200, 0, 0, mk(255, 1, 0, 0));
    directed("mul_udf", 10, 20, 0, 0, mk(0, 0, 1, 0));
    directed("mul_zero", 0, 150, 0, 0, mk(0, 0, 0, 1));
    directed("mul_inf", 255, 1, 0, 0, mk(255, 1, 0, 0));
    directed("mul_254", 191, 190, 0, 0, mk(254, 0, 0, 0));
    directed("mul_254_nadj", 191, 190, 0, 1, mk(255, 1, 0, 0));
    directed("mul_raw1", 64, 64, 0, 0, mk(1, 0, 0, 0));
    directed("mul_raw0", 63, 64, 0, 0, mk(0, 0, 1, 0));
    directed("div_130_125", 130, 125, 1, 0, mk(132, 0, 0, 0));
    directed("div_by_zero", 5, 0, 1, 0, mk(255, 1, 0, 0));
    directed("div_zero", 0, 5, 1, 0, mk(0, 0, 0, 1));
    directed("inf_over_zero", 0, 255, 0, 0, mk(255, 1, 0, 0));

    // Backpressure: two held, third refused until the consumer frees a slot
    base      = n_out;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(100 + 10 * i, 120, 0, 0);
      step();
    end
    chk("bp_third_refused", 32'(last_ir), 32'd0);
    chk("bp_accepted", 32'(exp_q.size()), 32'd2);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_ready", 32'(last_ir), 32'd0);
    end
    out_ready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      got = last_acc;
    end
    chk("bp_third_accepted", 32'(got), 32'd1);
    drain(10);
    chk("bp_drain_count", 32'(n_out - base), 32'd3);

    // Reset with two operations in flight
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(150, 140, 0, 0);
    step();
    drive(20, 30, 1, 1);
    step();
    in_valid = 1'b0;
    chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_result", 32'({expr, ovf, udf, zero}), 32'd0);
    exp_q.delete();
    hold_pend = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    directed("post_rst", 140, 120, 0, 1, mk(134, 0, 0, 0));

    // Random traffic with random backpressure
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      drive(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      step();
    end
    drain(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
